// File: rtl/data_lsu_if.sv
// Memory-side bus of the load/store unit: request/grant then read-valid.
interface data_lsu_if;
  logic        req;
  logic        gnt;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req, addr, we, be, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, addr, we, be, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/data_lsu.sv
// Load/store unit: turns control-FSM load/store strobes into one bus
// transaction, aligns/extends load data and reports misalignment/timeouts.
module data_lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              data_req_i,
  input  logic              data_write_enable_i,
  input  logic [2:0]        funct3_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       wdata_i,
  output logic              data_valid_o,
  output logic [31:0]       rdata_o,
  output logic              data_err_o,
  data_lsu_if.master        mem
);

  localparam int unsigned CntW = 8;
  localparam logic [CntW-1:0] TimeoutVal = CntW'(TIMEOUT);

  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_REQ  = 4'b0010,
    S_WAIT = 4'b0100,
    S_DONE = 4'b1000
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        alo_q, alo_d;
  logic              store_q, store_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              req_q, req_d;
  logic [31:0]       maddr_q, maddr_d;
  logic              we_q, we_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       mwd_q, mwd_d;

  logic              bad_c;
  logic [3:0]        st_be_c;
  logic [31:0]       st_wd_c;
  logic [7:0]        byte_c;
  logic [15:0]       half_c;
  logic [31:0]       ld_c;
  logic [CntW-1:0]   cnt_inc_c;

  // Illegal width code or misaligned address for the incoming access
  assign bad_c = (funct3_i[1:0] == 2'b11) || (funct3_i == 3'b110) ||
                 ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                 ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));

  assign cnt_inc_c = cnt_q + CntW'(1);

  // Store byte enables and lane-replicated write data
  always_comb begin
    st_be_c = 4'b1111;
    st_wd_c = wdata_i;
    case (funct3_i[1:0])
      2'b00: begin
        st_be_c = 4'b0001 << addr_i[1:0];
        st_wd_c = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        st_be_c = addr_i[1] ? 4'b1100 : 4'b0011;
        st_wd_c = {2{wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane extraction with sign/zero extension (funct3[2] = unsigned)
  always_comb begin
    case (alo_q)
      2'd0:    byte_c = mem.rdata[7:0];
      2'd1:    byte_c = mem.rdata[15:8];
      2'd2:    byte_c = mem.rdata[23:16];
      default: byte_c = mem.rdata[31:24];
    endcase
    half_c = alo_q[1] ? mem.rdata[31:16] : mem.rdata[15:0];
    case (f3_q[1:0])
      2'b00:   ld_c = {{24{byte_c[7] & ~f3_q[2]}}, byte_c};
      2'b01:   ld_c = {{16{half_c[15] & ~f3_q[2]}}, half_c};
      default: ld_c = mem.rdata;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    f3_d    = f3_q;
    alo_d   = alo_q;
    store_d = store_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    req_d   = 1'b0;
    maddr_d = maddr_q;
    we_d    = we_q;
    be_d    = be_q;
    mwd_d   = mwd_q;
    case (state_q)
      S_IDLE: begin
        if (data_write_enable_i || data_req_i) begin
          f3_d    = funct3_i;
          alo_d   = addr_i[1:0];
          store_d = data_write_enable_i;
          maddr_d = {addr_i[31:2], 2'b00};
          we_d    = data_write_enable_i;
          be_d    = data_write_enable_i ? st_be_c : 4'b1111;
          mwd_d   = st_wd_c;
          if (bad_c) begin
            state_d = S_DONE;
            valid_d = 1'b1;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d = S_REQ;
            req_d   = 1'b1;
            cnt_d   = '0;
          end
        end
      end
      S_REQ: begin
        if (mem.gnt) begin
          cnt_d = '0;
          if (store_q) begin
            state_d = S_DONE;
            valid_d = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end else begin
          cnt_d = cnt_inc_c;
          if (cnt_inc_c == TimeoutVal) begin
            state_d = S_DONE;
            valid_d = 1'b1;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            req_d = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (mem.rvalid) begin
          state_d = S_DONE;
          valid_d = 1'b1;
          rdata_d = ld_c;
        end else begin
          cnt_d = cnt_inc_c;
          if (cnt_inc_c == TimeoutVal) begin
            state_d = S_DONE;
            valid_d = 1'b1;
            err_d   = 1'b1;
            rdata_d = '0;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset aborts any access immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      f3_q    <= '0;
      alo_q   <= '0;
      store_q <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      req_q   <= 1'b0;
      maddr_q <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      mwd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      f3_q    <= f3_d;
      alo_q   <= alo_d;
      store_q <= store_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      req_q   <= req_d;
      maddr_q <= maddr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      mwd_q   <= mwd_d;
    end
  end

  assign data_valid_o = valid_q;
  assign data_err_o   = err_q;
  assign rdata_o      = rdata_q;
  assign mem.req      = req_q;
  assign mem.addr     = maddr_q;
  assign mem.we       = we_q;
  assign mem.be       = be_q;
  assign mem.wdata    = mwd_q;

endmodule
